// File: rtl/joystick_cmd_encoder.sv
// Joystick command encoder: press-edge detection, direction auto-repeat and a command FIFO.
// Optional feature macro JOYSTICK_RELEASE_EVT_EN adds release commands ({1'b1, code}).
module joystick_cmd_encoder #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_up,
    input  logic                        i_down,
    input  logic                        i_left,
    input  logic                        i_right,
    input  logic                        i_fire,
    output logic                        o_cmd_valid,
    input  logic                        i_cmd_ready,
    output logic [3:0]                  o_cmd,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow,
    output logic [1:0]                  o_rpt_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    // Button index k: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 FIRE; command code is k+1.
    localparam logic [2:0] PRIO [5] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3};

    typedef enum logic [1:0] {RPT_IDLE = 2'd0, RPT_DELAY = 2'd1, RPT_REPEAT = 2'd2} rpt_state_t;

    logic [4:0]       lvl, prev_q, rise;
    logic [4:0]       p_q, p_d, gnt_p, ev_p, keep_p, rpt_set;
    rpt_state_t       state_q, state_d;
    logic [1:0]       act_q, act_d, win;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pop, push, push_ok;
    logic [3:0]       push_cmd;
`ifdef JOYSTICK_RELEASE_EVT_EN
    logic [4:0]       r_q, r_d, gnt_r, fall, keep_r;
`endif

    assign lvl  = {i_fire, i_right, i_left, i_down, i_up};
    assign rise = lvl & ~prev_q;

    // Handshake: the head transfers on a posedge with o_cmd_valid && i_cmd_ready;
    // while valid && !ready the head (o_cmd) is held unchanged.
    assign o_cmd_valid = (count_q != '0);
    assign o_cmd       = o_cmd_valid ? mem_q[rd_ptr_q] : 4'h0;
    assign o_level     = count_q;
    assign o_overflow  = ovf_q;
    assign o_rpt_state = state_q;

    assign pop     = o_cmd_valid && i_cmd_ready;
    assign push_ok = (count_q != FULL_CNT) || pop;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        timer_d = timer_q;
        rpt_set = '0;
        win     = '0;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) win = 2'(i);
        end
        if (|rise[3:0]) begin
            state_d = RPT_DELAY;
            act_d   = win;
            timer_d = '0;
        end else if (state_q != RPT_IDLE) begin
            if (!lvl[act_q]) begin
                state_d = RPT_IDLE;
                timer_d = '0;
            end else if (timer_q == ((state_q == RPT_DELAY) ? DLY_LAST : PER_LAST)) begin
                state_d        = RPT_REPEAT;
                timer_d        = '0;
                rpt_set[act_q] = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Press bits always outrank release bits; within each group FIRE > UP > DOWN > LEFT > RIGHT.
    always_comb begin
        gnt_p    = '0;
        push     = 1'b0;
        push_cmd = 4'h0;
`ifdef JOYSTICK_RELEASE_EVT_EN
        gnt_r    = '0;
`endif
        if (push_ok) begin
            for (int i = 0; i < 5; i++) begin
                if (!push && p_q[PRIO[i]]) begin
                    push            = 1'b1;
                    gnt_p[PRIO[i]]  = 1'b1;
                    push_cmd        = {1'b0, PRIO[i] + 3'd1};
                end
            end
`ifdef JOYSTICK_RELEASE_EVT_EN
            for (int i = 0; i < 5; i++) begin
                if (!push && r_q[PRIO[i]]) begin
                    push            = 1'b1;
                    gnt_r[PRIO[i]]  = 1'b1;
                    push_cmd        = {1'b1, PRIO[i] + 3'd1};
                end
            end
`endif
        end
    end

    always_comb begin
        ev_p   = rise | rpt_set;
        keep_p = p_q & ~gnt_p;
        p_d    = keep_p | ev_p;
        ovf_d  = |(ev_p & keep_p);
`ifdef JOYSTICK_RELEASE_EVT_EN
        fall   = prev_q & ~lvl;
        keep_r = r_q & ~gnt_r;
        r_d    = keep_r | fall;
        ovf_d  = ovf_d | (|(fall & keep_r));
`endif
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            p_q      <= '0;
            state_q  <= RPT_IDLE;
            act_q    <= '0;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef JOYSTICK_RELEASE_EVT_EN
            r_q      <= '0;
`endif
        end else begin
            prev_q   <= lvl;
            p_q      <= p_d;
            state_q  <= state_d;
            act_q    <= act_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef JOYSTICK_RELEASE_EVT_EN
            r_q      <= r_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_cmd;
    end
endmodule
